// File: rtl/ssd_capture.sv
// Seven-segment display bus snooper: recovers per-digit characters from a multiplexed
// an/seg/dp bus. Optional decimal-point capture is enabled with SSD_CAPTURE_DP_EN.
module ssd_capture #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter logic [3:0]  FRAME_MASK = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [19:0] code,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        err_multi,
  output logic        err_glyph
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  localparam logic [11:0] SmpIdle   = {4'hF, 7'h7F, 1'b1};
  localparam logic [7:0]  StableLd  = 8'(STABLE_CNT);
  localparam logic [15:0] TimeoutLd = 16'(TIMEOUT);
  localparam logic [4:0]  CodeBad   = 5'h1E;

  // Segment pattern (active-low, {g,f,e,d,c,b,a}) to character code.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] c;
    case (s)
      7'b1000000: c = 5'h00;
      7'b1111001: c = 5'h01;
      7'b0100100: c = 5'h02;
      7'b0110000: c = 5'h03;
      7'b0011001: c = 5'h04;
      7'b0010010: c = 5'h05;
      7'b0000010: c = 5'h06;
      7'b1111000: c = 5'h07;
      7'b0000000: c = 5'h08;
      7'b0010000: c = 5'h09;
      7'b0001000: c = 5'h0A;
      7'b0000011: c = 5'h0B;
      7'b1000110: c = 5'h0C;
      7'b0100001: c = 5'h0D;
      7'b0000110: c = 5'h0E;
      7'b0001110: c = 5'h0F;
      7'b1000111: c = 5'h10;
      7'b1111111: c = 5'h1F;
      default:    c = CodeBad;
    endcase
    return c;
  endfunction

  logic [3:0] an_s1_q, an_s2_q;
  logic [6:0] seg_s1_q, seg_s2_q;
  logic       dp_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q  <= 4'hF;
      an_s2_q  <= 4'hF;
      seg_s1_q <= 7'h7F;
      seg_s2_q <= 7'h7F;
    end else begin
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
    end
  end

`ifdef SSD_CAPTURE_DP_EN
  logic dp_s1_q, dp_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1_q <= 1'b1;
      dp_s2_q <= 1'b1;
    end else begin
      dp_s1_q <= dp;
      dp_s2_q <= dp_s1_q;
    end
  end

  assign dp_s = dp_s2_q;
`else
  logic unused_dp;
  assign unused_dp = dp;
  // Constant dp keeps it out of the stability comparison.
  assign dp_s = 1'b1;
`endif

  logic [11:0] smp, smp_q;
  logic [3:0]  sel;
  logic        one_hot, multi, same;

  assign smp     = {an_s2_q, seg_s2_q, dp_s};
  assign sel     = ~an_s2_q;
  assign one_hot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign multi   = (sel != 4'd0) && !one_hot;
  assign same    = (smp == smp_q);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       capture;
  logic       err_multi_q, err_multi_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    err_multi_d = err_multi_q | multi;
    if (!one_hot) begin
      state_d = StIdle;
      cnt_d   = 8'd0;
    end else if (state_q == StIdle || !same) begin
      state_d = StSettle;
      cnt_d   = 8'd1;
    end else begin
      unique case (state_q)
        StSettle: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == StableLd) begin
            state_d = StHold;
            capture = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      smp_q       <= SmpIdle;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      smp_q       <= smp;
      err_multi_q <= err_multi_d;
    end
  end

  logic [4:0]            glyph;
  logic [3:0]            cap_vec;
  logic [3:0][4:0]       code_q, code_d;
  logic [3:0][15:0]      timer_q, timer_d;
  logic [3:0]            valid_q, valid_d;
  logic [3:0]            seen_q, seen_d;
  logic                  frame_q, frame_d;
  logic                  err_glyph_q, err_glyph_d;

  assign glyph   = decode(seg_s2_q);
  assign cap_vec = capture ? sel : 4'd0;

  always_comb begin
    code_d      = code_q;
    timer_d     = timer_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    err_glyph_d = err_glyph_q | (capture && glyph == CodeBad);
    frame_d     = (FRAME_MASK != 4'd0) && ((seen_q & FRAME_MASK) == FRAME_MASK);
    if (frame_d) begin
      seen_d = 4'd0;
    end
    for (int i = 0; i < 4; i++) begin
      if (timer_q[i] != 16'd0) begin
        timer_d[i] = timer_q[i] - 16'd1;
        if (timer_q[i] == 16'd1) begin
          valid_d[i] = 1'b0;
          seen_d[i]  = 1'b0;
        end
      end
      // A capture overrides a same-cycle timeout.
      if (cap_vec[i]) begin
        code_d[i]  = glyph;
        timer_d[i] = TimeoutLd;
        valid_d[i] = 1'b1;
        seen_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q      <= '1;
      timer_q     <= '0;
      valid_q     <= 4'd0;
      seen_q      <= 4'd0;
      frame_q     <= 1'b0;
      err_glyph_q <= 1'b0;
    end else begin
      code_q      <= code_d;
      timer_q     <= timer_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      frame_q     <= frame_d;
      err_glyph_q <= err_glyph_d;
    end
  end

`ifdef SSD_CAPTURE_DP_EN
  logic [3:0] dpo_q, dpo_d;

  always_comb begin
    dpo_d = dpo_q;
    for (int i = 0; i < 4; i++) begin
      if (cap_vec[i]) begin
        dpo_d[i] = ~dp_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpo_q <= 4'd0;
    end else begin
      dpo_q <= dpo_d;
    end
  end

  assign dp_out = dpo_q;
`else
  assign dp_out = 4'd0;
`endif

  assign code        = code_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign err_multi   = err_multi_q;
  assign err_glyph   = err_glyph_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Self-checking bench for ssd_capture: directed scenarios plus random bus traffic,
// all compared every cycle against a sample-history reference model.
module tb_ssd_capture;

  localparam int          STABLE = 4;
  localparam int          TMO    = 4096;
  localparam logic [3:0]  MASK   = 4'b0111;
`ifdef SSD_CAPTURE_DP_EN
  localparam bit DpEn = 1'b1;
`else
  localparam bit DpEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [19:0] code;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        err_multi;
  logic        err_glyph;

  always #5 clk = ~clk;

  ssd_capture #(
    .STABLE_CNT (STABLE),
    .TIMEOUT    (TMO),
    .FRAME_MASK (MASK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .code        (code),
    .digit_valid (digit_valid),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .err_multi   (err_multi),
    .err_glyph   (err_glyph)
  );

  int total = 0;
  int bad   = 0;

  // Glyph k of this table decodes to code k; blank and unknowns handled separately.
  logic [6:0] glyph_tab [17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                                 7'h47};

  // Reference model state: bus history plus per-digit results.
  logic [11:0] m_s1, m_s2, m_prev;
  int          m_run;
  logic [4:0]  m_code [4];
  int          m_tmr  [4];
  logic [3:0]  m_valid, m_seen, m_dpo;
  logic        m_frame, m_emulti, m_eglyph;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 5'h1F;
    for (int k = 0; k < 17; k++) begin
      if (glyph_tab[k] == s) return 5'(k);
    end
    return 5'h1E;
  endfunction

  task automatic model_reset();
    m_s1 = {4'hF, 7'h7F, 1'b1};
    m_s2 = m_s1;
    m_prev = m_s1;
    m_run = 0;
    for (int i = 0; i < 4; i++) begin
      m_code[i] = 5'h1F;
      m_tmr[i]  = 0;
    end
    m_valid = 4'd0;
    m_seen = 4'd0;
    m_dpo = 4'd0;
    m_frame = 1'b0;
    m_emulti = 1'b0;
    m_eglyph = 1'b0;
  endtask

  // One rising edge of behaviour, using the inputs present at that edge.
  task automatic model_step();
    logic [11:0] cur;
    logic [3:0]  lows;
    int          nlow;
    if (rst) begin
      model_reset();
    end else begin
      cur  = m_s2;
      lows = ~cur[11:8];
      nlow = $countones(lows);
      if (nlow >= 2) m_emulti = 1'b1;
      if (nlow == 1) m_run = (cur == m_prev && m_run > 0) ? m_run + 1 : 1;
      else m_run = 0;
      m_prev = cur;
      m_frame = ((m_seen & MASK) == MASK);
      if (m_frame) m_seen = 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (m_tmr[i] > 0) begin
          m_tmr[i]--;
          if (m_tmr[i] == 0) begin
            m_valid[i] = 1'b0;
            m_seen[i]  = 1'b0;
          end
        end
        if (nlow == 1 && m_run == STABLE && lows[i]) begin
          m_code[i] = ref_decode(cur[7:1]);
          if (m_code[i] == 5'h1E) m_eglyph = 1'b1;
          m_dpo[i]   = DpEn ? ~cur[0] : 1'b0;
          m_valid[i] = 1'b1;
          m_seen[i]  = 1'b1;
          m_tmr[i]   = TMO;
        end
      end
      m_s2 = m_s1;
      m_s1 = {an, seg, DpEn ? dp : 1'b1};
    end
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("code", code, {m_code[3], m_code[2], m_code[1], m_code[0]});
    chk("digit_valid", 20'(digit_valid), 20'(m_valid));
    chk("dp_out", 20'(dp_out), 20'(m_dpo));
    chk("frame_valid", 20'(frame_valid), 20'(m_frame));
    chk("err_multi", 20'(err_multi), 20'(m_emulti));
    chk("err_glyph", 20'(err_glyph), 20'(m_eglyph));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d);
    an  = a;
    seg = s;
    dp  = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rot_seg [3];
    logic [3:0] multi_tab [5];
    int         fcnt;
    int         r, n, d;
    rot_seg   = '{7'h46, 7'h47, 7'h0E};
    multi_tab = '{4'b1100, 4'b0000, 4'b1010, 4'b0110, 4'b1000};

    rst = 1'b1;
    drive(4'hF, 7'h7F, 1'b1);
    model_reset();
    repeat (3) tick();
    #2 rst = 1'b0;
    chk("rst_code", code, 20'hFFFFF);
    chk("rst_valid", 20'(digit_valid), 20'h0);
    chk("rst_dp", 20'(dp_out), 20'h0);
    chk("rst_frame", 20'(frame_valid), 20'h0);
    chk("rst_emulti", 20'(err_multi), 20'h0);
    chk("rst_eglyph", 20'(err_glyph), 20'h0);

    // C on digit 0: captured exactly 2+4 cycles after it appears.
    drive(4'b1110, 7'h46, 1'b1);
    repeat (5) tick();
    chk("c_early_valid", 20'(digit_valid), 20'h0);
    tick();
    chk("c_code0", 20'(code[4:0]), 20'h0C);
    chk("c_valid", 20'(digit_valid), 20'h1);
    repeat (4) tick();

    // Segments toggling faster than the stability window never capture.
    for (int k = 0; k < 10; k++) begin
      drive(4'b1101, (k % 2) ? 7'h47 : 7'h46, 1'b1);
      repeat (3) tick();
    end
    chk("toggle_valid1", 20'(digit_valid[1]), 20'h0);

    // Recapture digit 3 in the very cycle its timer expires.
    drive(4'b0111, 7'h06, 1'b0);
    repeat (8) tick();
    chk("d3_valid", 20'(digit_valid[3]), 20'h1);
    drive(4'hF, 7'h7F, 1'b1);
    for (int g = 0; g < TMO + 10 && m_tmr[3] > 6; g++) tick();
    drive(4'b0111, 7'h21, 1'b1);
    repeat (6) tick();
    chk("collide_valid3", 20'(digit_valid[3]), 20'h1);
    chk("collide_code3", 20'(code[19:15]), 20'h0D);

    // Timeout of digit 3 with the bus idle.
    drive(4'hF, 7'h7F, 1'b1);
    repeat (TMO - 1) tick();
    chk("tmo_still_valid3", 20'(digit_valid[3]), 20'h1);
    repeat (2) tick();
    chk("tmo_valid3", 20'(digit_valid[3]), 20'h0);
    chk("tmo_code3_kept", 20'(code[19:15]), 20'h0D);

    // C/L/F rotation: one frame per rotation.
    for (int rot = 0; rot < 2; rot++) begin
      fcnt = 0;
      for (int dg = 0; dg < 3; dg++) begin
        drive(~(4'b0001 << dg), rot_seg[dg], 1'b1);
        repeat (1024) begin
          tick();
          if (frame_valid) fcnt++;
        end
      end
      chk("rot_frames", 20'(fcnt), 20'h1);
    end
    chk("rot_code", 20'(code[14:0]), {5'h0, 5'h0F, 5'h10, 5'h0C});

    // Two anodes low for one cycle sets a sticky error.
    drive(4'b1100, 7'h46, 1'b1);
    tick();
    drive(4'hF, 7'h7F, 1'b1);
    repeat (3) tick();
    chk("multi_set", 20'(err_multi), 20'h1);
    repeat (20) tick();
    chk("multi_sticky", 20'(err_multi), 20'h1);

    // Random bus traffic.
    for (int b = 0; b < 400; b++) begin
      r = $urandom_range(0, 99);
      if (r < 8) an = 4'hF;
      else if (r < 10) an = multi_tab[$urandom_range(0, 4)];
      else an = ~(4'b0001 << $urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 80) seg = glyph_tab[$urandom_range(0, 16)];
      else if (r < 88) seg = 7'h7F;
      else seg = 7'($urandom);
      dp = 1'($urandom);
      n = $urandom_range(1, 9);
      repeat (n) tick();
    end

    // Reset in the middle of settling digit 2.
    drive(4'b1011, 7'h24, 1'b0);
    repeat (4) tick();
    #1 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("midrst_code", code, 20'hFFFFF);
    chk("midrst_valid", 20'(digit_valid), 20'h0);
    repeat (2) tick();
    #2 rst = 1'b0;
    d = 0;
    repeat (5) begin
      tick();
      if (frame_valid) d++;
    end
    chk("midrst_no_early", 20'(digit_valid), 20'h0);
    tick();
    chk("midrst_capture", 20'(digit_valid), 20'h4);
    repeat (5) begin
      tick();
      if (frame_valid) d++;
    end
    chk("midrst_no_frame", 20'(d), 20'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 Parameter STABLE_CNT, default 4: number of consecutive identical an/seg samples required before a digit is accepted (legal 2..255).
REQ-002 Parameter TIMEOUT, default 4096: number of cycles without an accepted refresh after which a digit is invalidated (legal 16..65535).
REQ-003 Parameter FRAME_MASK, default 4'b0111: set of digit positions that must all be accepted to complete a frame.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 an  input  4  anode enables from the display driver, active-low; an[i] low selects digit i.
REQ-007 seg  input  7  segment lines, active-low; seg[0]=a … seg[6]=g.
REQ-008 dp  input  1  decimal point line, active-low.
REQ-009 code  output  20  decoded character per digit; code[5i+4:5i] is digit i.
REQ-010 digit_valid  output  4  bit i high while code for digit i is current.
REQ-011 dp_out  output  4  captured decimal point per digit, active-high.
REQ-012 frame_valid  output  1  one-cycle pulse on frame completion.
REQ-013 err_multi  output  1  sticky flag: more than one anode low was sampled.
REQ-014 err_glyph  output  1  sticky flag: an unrecognised segment pattern was accepted.

Function
REQ-015 Inputs are sampled through a 2-flop synchroniser; all decisions use the synchronised values (2-cycle input latency).
REQ-016 Per-sample state machine:
- IDLE when an==4'b1111.
- SETTLE while an is one-hot-low and {an,seg,dp} is unchanged, with a stability counter incrementing.
- HOLD once the counter reaches STABLE_CNT.
- Any change of {an,seg,dp} returns to SETTLE with the counter at 1 (or to IDLE if an==4'b1111).
REQ-017 On the SETTLE→HOLD transition for digit i:
- write code[i] and dp_out[i];
- set digit_valid[i] and seen[i];
- reload timer[i] to TIMEOUT.
Exactly one capture occurs per HOLD entry; remaining in HOLD does not recapture.
REQ-018 Decode table (seg as 7-bit active-low value → code):
- hex glyphs 0–F → 5'h00–5'h0F (standard segment patterns; b and d lower-case);
- 7'b1000111 (L) → 5'h10;
- 7'b1111111 (blank) → 5'h1F;
- any other pattern → 5'h1E and err_glyph set.
REQ-019 C = 7'b1000110 → 5'h0C; F = 7'b0001110 → 5'h0F.
REQ-020 When an has two or more low bits: set err_multi, enter IDLE, capture nothing, and clear the stability counter.
REQ-021 timer[i] decrements every cycle while non-zero. On reaching 0, clear digit_valid[i] and seen[i]; code[i] keeps its last value.
REQ-022 frame_valid pulses for exactly one cycle, in the cycle after (seen & FRAME_MASK)==FRAME_MASK first becomes true. seen is cleared in that same cycle.
REQ-023 A capture that lands in the same cycle as a timeout of the same digit takes priority: the digit stays valid and its timer is reloaded.
REQ-024 Captures of digits outside FRAME_MASK update code, digit_valid and timer but never contribute to frame_valid.

Reset
REQ-025 Asserting rst asynchronously forces the following values: code=20'hFFFFF (all blank), digit_valid=0, dp_out=0, frame_valid=0, err_multi=0, err_glyph=0, seen=0, all timers 0, state IDLE, synchronisers to an=4'b1111, seg=7'h7F, dp=1.
REQ-026 Reset asserted mid-SETTLE discards the partial capture; after release, the first capture requires a full STABLE_CNT run.

Configuration
REQ-027 Macro SSD_CAPTURE_DP_EN.
- Defined: dp is synchronised, takes part in the stability comparison, and is captured into dp_out.
- Undefined: dp is ignored and dp_out is tied to 4'b0000.

Verification
REQ-028 Drive an=1110, seg=1000110 held for 10 cycles → after 2+4 cycles code[4:0]=5'h0C, digit_valid=4'b0001.
REQ-029 Rotate C/L/F on digits 0/1/2 with 1024 cycles per digit → frame_valid pulses once per rotation; code[14:0]={5'h0F,5'h10,5'h0C}.
REQ-030 Drive an=1101 with seg toggling every 3 cycles (below STABLE_CNT) → no capture; digit_valid[1] stays 0.
REQ-031 Drive an=1100 for 1 cycle → err_multi=1 and stays 1 until rst.
REQ-032 Capture digit 3, then hold an=1111 for TIMEOUT+1 cycles → digit_valid[3] drops to 0; code[19:15] unchanged.
REQ-033 Assert rst during SETTLE of digit 2 → all outputs at reset values; frame_valid=0 after release.
